// File: rtl/prog_loader_if.sv
// Byte-stream upload and instruction-memory write bus between the host-side
// byte source and the program loader.
interface prog_loader_if #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 32
);
    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   byte_last;
    logic                   byte_ready;
    logic                   imem_we;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        output byte_last,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_last,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Assembles a little-endian byte stream into instruction words, writes them to
// instruction memory and releases the CPU reset a fixed delay after the image ends.
module prog_loader #(
    parameter int PC_WIDTH      = 16,
    parameter int INSTR_WIDTH   = 32,
    parameter int MAX_WORDS     = 1024,
    parameter int RELEASE_DELAY = 4
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         loading,
    output logic         done,
    output logic         overflow
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    state_e                 state_q;
    logic [1:0]             lane_q;
    logic [INSTR_WIDTH-1:0] buf_q;
    logic [INSTR_WIDTH-1:0] wdata_q;
    logic [PC_WIDTH-1:0]    addr_q;
    logic [CNT_W-1:0]       word_cnt_q;
    logic [7:0]             hold_cnt_q;
    logic                   we_q;
    logic                   ready_q;
    logic                   cpu_rst_q;
    logic                   loading_q;
    logic                   done_q;
    logic                   overflow_q;

    logic                   hs_d;
    logic                   full_d;
    logic                   emit_d;
    logic [INSTR_WIDTH-1:0] word_d;

    // Handshake decode and the word as it would look with the current byte merged in.
    always_comb begin
        hs_d   = bus.byte_valid && ready_q;
        full_d = (word_cnt_q == CNT_W'(MAX_WORDS));
        // Upper lanes of buf_q are always zero here, so a partial word is zero padded.
        word_d = buf_q | (INSTR_WIDTH'(bus.byte_data) << {lane_q, 3'b000});
        if (hs_d && !full_d && (bus.byte_last || (lane_q == 2'd3))) begin
            emit_d = 1'b1;
        end else begin
            emit_d = 1'b0;
        end
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            lane_q     <= 2'd0;
            buf_q      <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            hold_cnt_q <= 8'd0;
            we_q       <= 1'b0;
            ready_q    <= 1'b1;
            cpu_rst_q  <= 1'b1;
            loading_q  <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                addr_q <= addr_q + PC_WIDTH'(4);
            end
            case (state_q)
                ST_LOAD: begin
                    if (hs_d) begin
                        if (full_d) begin
                            // Image larger than memory: drop the byte and lock up.
                            state_q    <= ST_ERR;
                            overflow_q <= 1'b1;
                            ready_q    <= 1'b0;
                            loading_q  <= 1'b0;
                        end else begin
                            if (emit_d) begin
                                wdata_q    <= word_d;
                                we_q       <= 1'b1;
                                buf_q      <= '0;
                                lane_q     <= 2'd0;
                                word_cnt_q <= word_cnt_q + CNT_W'(1);
                            end else begin
                                buf_q  <= word_d;
                                lane_q <= lane_q + 2'd1;
                            end
                            if (bus.byte_last) begin
                                state_q    <= ST_HOLD;
                                ready_q    <= 1'b0;
                                loading_q  <= 1'b0;
                                hold_cnt_q <= 8'(RELEASE_DELAY - 1);
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == 8'd0) begin
                        state_q   <= ST_RUN;
                        cpu_rst_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    done_q <= 1'b1;
                end
                ST_ERR: begin
                    cpu_rst_q <= 1'b1;
                    we_q      <= 1'b0;
                end
                default: begin
                    state_q   <= ST_ERR;
                    cpu_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    loading_q <= 1'b0;
                    done_q    <= 1'b0;
                    we_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign loading        = loading_q;
    assign done           = done_q;
    assign overflow       = overflow_q;
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL take parameter PC_WIDTH, default 16, as the width of the instruction-memory byte address, matching the CPU program counter.
REQ-002 The block SHALL take parameter INSTR_WIDTH, default 32, as the instruction word width; only 32 is supported.
REQ-003 The block SHALL take parameter MAX_WORDS, default 1024, as the instruction-memory capacity in words.
REQ-004 The block SHALL take parameter RELEASE_DELAY, default 4, as the number of cycles cpu_rst is held after the final write; legal range is 1..255.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 byte_valid  in  1  upstream byte available.
REQ-008 byte_data  in  8  program byte, little-endian within each word.
REQ-009 byte_last  in  1  qualifies byte_data as the final byte of the image.
REQ-010 byte_ready  out  1  block accepts a byte this cycle.
REQ-011 imem_we  out  1  instruction-memory write strobe.
REQ-012 imem_addr  out  PC_WIDTH  byte address of the word being written; always word aligned.
REQ-013 imem_wdata  out  INSTR_WIDTH  word being written.
REQ-014 cpu_rst  out  1  reset to the CPU core, active-high.
REQ-015 loading  out  1  high while the block is in state LOAD.
REQ-016 done  out  1  high while the block is in state RUN.
REQ-017 overflow  out  1  sticky image-too-large error flag.

Function
REQ-018 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both 1 (handshake); byte_data and byte_last SHALL be ignored in all other cycles.
REQ-019 The FSM SHALL have the states LOAD, HOLD, RUN and ERR and SHALL enter LOAD on reset.
REQ-020 In LOAD, byte_ready SHALL be 1 in every cycle, with no back-pressure; in HOLD, RUN and ERR, byte_ready SHALL be 0.
REQ-021 A 2-bit lane counter SHALL place each accepted byte at bits [8*lane+7 : 8*lane] of an assembly buffer and SHALL wrap from 3 to 0.
REQ-022 On the handshake of lane 3, or of any byte with byte_last=1, the assembled word SHALL be copied to imem_wdata, and imem_we SHALL be 1 for exactly the next cycle.
REQ-023 The buffer SHALL be separate from imem_wdata, so a byte accepted in the imem_we cycle SHALL NOT corrupt the word being written.
REQ-024 For a partial final word, the unfilled upper lanes SHALL be written as 0x00.
REQ-025 imem_addr SHALL start at 0 and SHALL advance by 4 in the cycle after each imem_we pulse; arithmetic is modulo 2^PC_WIDTH.
REQ-026 A word counter SHALL count completed writes.
REQ-027 If a byte handshake occurs while the word counter equals MAX_WORDS, that byte SHALL NOT be written, the FSM SHALL enter ERR, and overflow SHALL be set.
REQ-028 In ERR, cpu_rst SHALL stay 1 and imem_we SHALL stay 0 until rst.
REQ-029 The handshake with byte_last=1 SHALL move the FSM LOAD->HOLD in the following cycle; that cycle also carries the final imem_we.
REQ-030 HOLD SHALL last exactly RELEASE_DELAY cycles, counted by a down-counter, and then move to RUN.
REQ-031 cpu_rst SHALL be 1 in LOAD, HOLD and ERR, and 0 only in RUN.
REQ-032 RUN SHALL be terminal until rst; byte_valid in RUN SHALL be ignored.
REQ-033 A byte with byte_last=1 on lane 3 SHALL produce a single write, not a full write followed by an empty one.
REQ-034 If rst and a handshake coincide, rst SHALL win and the byte SHALL be dropped.

Reset
REQ-035 Reset SHALL produce state LOAD, lane 0, word counter 0, imem_addr 0, imem_wdata 0, imem_we 0, cpu_rst 1, loading 1, done 0, overflow 0 and byte_ready 1, effective from the next edge.
REQ-036 Reset asserted mid-load or in RUN SHALL discard any partially assembled word and restart the image at address 0, and cpu_rst SHALL return to 1 at the edge that samples rst.

Verification
REQ-037 Bytes 13,05,10,00 (last on the 4th) -> one imem_we with addr 0x0000 and wdata 0x00100513; HOLD for 4 cycles with cpu_rst=1; then done=1 and cpu_rst=0.
REQ-038 Eight back-to-back bytes 01..08 (last on the 8th) -> writes (0x0000, 0x04030201) and (0x0004, 0x08070605); byte_ready stays 1 throughout and no byte is lost during the first imem_we cycle.
REQ-039 Bytes AA,BB,CC (last on CC) -> a single write of 0x00CCBBAA at 0x0000, then HOLD.
REQ-040 MAX_WORDS=2 with 9 bytes -> two writes, then on the 9th byte: no write, overflow=1, state ERR, cpu_rst stuck at 1 for 20 cycles.
REQ-041 rst pulsed after 6 bytes, then 4 bytes 11,22,33,44 (last) -> write 0x44332211 at 0x0000; no trace of the earlier bytes.
REQ-042 byte_valid toggled randomly during HOLD and RUN -> byte_ready=0, no imem_we, and the state sequence is unchanged.
